rotate_design: RTL and testbench

- 32-bit funnel shifter / rotate unit for one round of the datapath.
- Concatenates two 32-bit words {A,B} into a 64-bit value, shifts it left or right by K (0..31) and returns a 32-bit window.
- When A==B this is a true 32-bit rotate of A.
- Result is registered: one clock of latency. Sits between operand registers and round-output logic.

---
 rtl/rotate_design.sv | 48 ++++
 tb/tb_rotate_design.sv | 110 +++++++++++
 2 files changed

// File: rtl/rotate_design.sv
// 32-bit funnel shifter / rotate unit: shifts {A,B} left or right by K and
// registers a 32-bit window of the result. A==B gives a true rotate of A.
module rotate_design #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       K,
  input  logic             right,
  output logic [WIDTH-1:0] F
);

  logic [2*WIDTH-1:0] rsh;
  logic [2*WIDTH-1:0] lsh;
  logic [WIDTH-1:0]   f_d;
  logic [WIDTH-1:0]   f_q;

  // Logarithmic funnel: stages 16, 8, 4, 2, 1 driven by K[4] down to K[0].
  always_comb begin
    rsh = {A, B};
    lsh = {A, B};
    for (int i = 4; i >= 0; i--) begin
      if (K[i]) begin
        rsh = rsh >> (1 << i);
        lsh = lsh << (1 << i);
      end
    end
  end

  // Window select: right keeps the low word, left keeps the high word.
  always_comb begin
    f_d = right ? rsh[WIDTH-1:0] : lsh[2*WIDTH-1:WIDTH];
  end

  // ---- stage boundary: registered output ----
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q <= '0;
    end else begin
      f_q <= f_d;
    end
  end

  assign F = f_q;

endmodule

// File: tb/tb_rotate_design.sv
// Scoreboard bench for rotate_design: directed cases plus randomized
// operations checked against a bit-level funnel model.
module tb_rotate_design;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [4:0]  K = '0;
  logic        right = 1'b0;
  logic [31:0] F;

  int errors = 0;
  int checks = 0;
  logic [31:0] expq[$];
  string       nameq[$];

  always #5 clk = ~clk;

  rotate_design #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .K(K), .right(right), .F(F)
  );

  // Output bit j comes from concatenation bit j+K (right) or 32+j-K (left).
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input int k, input logic r);
    logic [63:0] cat;
    logic [31:0] f;
    cat = {a, b};
    for (int j = 0; j < 32; j++) begin
      f[j] = r ? cat[j + k] : cat[32 + j - k];
    end
    return f;
  endfunction

  task automatic issue(input logic rs, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] k, input logic r, input logic [31:0] exp,
                       input string nm);
    @(negedge clk);
    rst = rs; A = a; B = b; K = k; right = r;
    expq.push_back(exp);
    nameq.push_back(nm);
  endtask

  task automatic issue_rand(input logic rs, input string nm);
    logic [31:0] a, b;
    logic [4:0]  k;
    logic        r;
    a = $urandom; b = $urandom; k = 5'($urandom_range(0, 31)); r = 1'($urandom);
    issue(rs, a, b, k, r, rs ? 32'h0 : model(a, b, int'(k), r), nm);
  endtask

  // Monitor: every edge the DUT presents a result for the oldest issued op.
  always begin
    logic [31:0] e;
    string       n;
    @(posedge clk);
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      n = nameq.pop_front();
      checks++;
      if (F !== e) begin
        errors++;
        $display("FAIL %s: F=%08h expected %08h", n, F, e);
      end
    end
  end

  initial begin
    issue_rand(1'b1, "reset0");
    issue_rand(1'b1, "reset1");
    issue_rand(1'b1, "reset_hold");
    issue(1'b0, 32'hFFFF0000, 32'h0000FFFF, 5'd1,  1'b1, 32'h00007FFF, "r_k1");
    issue(1'b0, 32'hFFFF0000, 32'h0000FFFF, 5'd1,  1'b0, 32'hFFFE0000, "l_k1");
    issue(1'b0, 32'hFFFF0000, 32'h0000FFFF, 5'd2,  1'b1, 32'h00003FFF, "r_k2");
    issue(1'b0, 32'hFFFF0000, 32'h0000FFFF, 5'd2,  1'b0, 32'hFFFC0000, "l_k2");
    issue(1'b0, 32'hFFFF0000, 32'h0000FFFF, 5'd31, 1'b1, 32'hFFFE0000, "r_k31");
    issue(1'b0, 32'hFFFF0000, 32'h0000FFFF, 5'd31, 1'b0, 32'h00007FFF, "l_k31");
    issue(1'b0, 32'h00011000, 32'h00100100, 5'd4,  1'b1, 32'h00010010, "r_k4");
    issue(1'b0, 32'h00011000, 32'h00100100, 5'd4,  1'b0, 32'h00110000, "l_k4");
    issue(1'b0, 32'h12345678, 32'h9ABCDEF0, 5'd0,  1'b1, 32'h9ABCDEF0, "r_k0");
    issue(1'b0, 32'h12345678, 32'h9ABCDEF0, 5'd0,  1'b0, 32'h12345678, "l_k0");
    issue(1'b0, 32'h80000001, 32'h80000001, 5'd1,  1'b1, 32'hC0000000, "rot_k1");
    for (int i = 0; i < 8; i++) begin
      issue_rand(i == 4, (i == 4) ? "b2b_rst" : "b2b");
    end
    for (int i = 0; i < 200; i++) begin
      issue_rand(1'b0, "rand");
    end
    for (int i = 1; i < 32; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      issue(1'b0, a, b, 5'(i),      1'b0, model(a, b, i, 1'b0),      "sym_l");
      issue(1'b0, a, b, 5'(32 - i), 1'b1, model(a, b, i, 1'b0),      "sym_r");
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
